// File: rtl/mem_dump_reader_pkg.sv
// Shared definitions for the memory dump reader: FSM state encoding,
// data-memory geometry constants and the checksum update helper.
package mem_dump_reader_pkg;

   // FSM state encoding; the values are visible on debug taps, so they are fixed
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Data-memory byte-address width (4K bytes)
   localparam int ADDR_WIDTH     = 12;

   // Each dumped word is transmitted as this many bytes
   localparam int BYTES_PER_WORD = 4;

   // Running checksum: XOR of every byte handed to the transmitter
   function automatic logic [7:0] checksum_update(input logic [7:0] cs,
                                                  input logic [7:0] data);
      return cs ^ data;
   endfunction

endpackage

// File: rtl/mem_dump_reader.sv
// Memory dump reader: streams i_word_count 32-bit words, byte by byte in
// increasing address order, from an external byte-wide asynchronous data
// memory to a UART-style valid/ready transmitter, keeping an XOR checksum.
// The block only reads memory; the memory itself lives outside this module.
module mem_dump_reader #(
   parameter int ADDR_WIDTH  = mem_dump_reader_pkg::ADDR_WIDTH,
   parameter int COUNT_WIDTH = 11
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic [ADDR_WIDTH-1:0]  i_base_addr,
   input  logic [COUNT_WIDTH-1:0] i_word_count,
   output logic [ADDR_WIDTH-1:0]  o_mem_addr,
   input  logic [7:0]             i_mem_data,
   output logic [7:0]             o_tx_data,
   output logic                   o_tx_valid,
   input  logic                   i_tx_ready,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [7:0]             o_checksum
);

   import mem_dump_reader_pkg::*;

   // Remaining-byte counter must hold word_count * 4
   localparam int REM_WIDTH = COUNT_WIDTH + 2;

   localparam logic [ADDR_WIDTH-1:0]  ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [REM_WIDTH-1:0]   REM_ZERO   = {REM_WIDTH{1'b0}};
   localparam logic [REM_WIDTH-1:0]   REM_ONE    = {{(REM_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = {COUNT_WIDTH{1'b0}};

   state_t                 state_q,    state_d;
   logic [ADDR_WIDTH-1:0]  addr_q,     addr_d;
   logic [REM_WIDTH-1:0]   rem_q,      rem_d;
   logic [7:0]             tx_data_q,  tx_data_d;
   logic                   tx_valid_q, tx_valid_d;
   logic                   busy_q,     busy_d;
   logic                   done_q,     done_d;
   logic [7:0]             checksum_q, checksum_d;

   logic                   handshake_s;
   logic [REM_WIDTH-1:0]   rem_start_s;

   // A byte is consumed only while we are presenting one; ready alone does nothing
   assign handshake_s = (state_q == SEND) && tx_valid_q && i_tx_ready;

   // Total bytes to send for the requested word count
   assign rem_start_s = REM_WIDTH'(i_word_count) * REM_WIDTH'(BYTES_PER_WORD);

   // Next-state and next-output logic for the dump sequencer
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      checksum_d = checksum_q;

      case (state_q)
         IDLE: begin
            // Start is only honoured here, so a request while busy is dropped
            if (i_start) begin
               addr_d     = i_base_addr;
               rem_d      = rem_start_s;
               checksum_d = 8'h00;
               if (i_word_count == COUNT_ZERO) begin
                  state_d = DONE;
               end else begin
                  state_d = FETCH;
               end
            end else begin
               state_d = IDLE;
            end
         end

         FETCH: begin
            // Memory is asynchronous: the byte at addr_q is already on i_mem_data
            tx_data_d  = i_mem_data;
            tx_valid_d = 1'b1;
            state_d    = SEND;
         end

         SEND: begin
            // Hold data/valid steady until the transmitter takes the byte
            if (handshake_s) begin
               checksum_d = checksum_update(checksum_q, tx_data_q);
               addr_d     = addr_q + ADDR_ONE;
               rem_d      = rem_q - REM_ONE;
               tx_valid_d = 1'b0;
               if (rem_q == REM_ONE) begin
                  state_d = DONE;
               end else begin
                  state_d = FETCH;
               end
            end else begin
               state_d = SEND;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
         end
      endcase

      // Status outputs are registered and reflect the state being entered
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and output registers; reset aborts any dump in progress
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= IDLE;
         addr_q     <= ADDR_ZERO;
         rem_q      <= REM_ZERO;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         checksum_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         checksum_q <= checksum_d;
      end
   end

   // The memory address comes straight from the address register
   assign o_mem_addr = addr_q;
   assign o_tx_data  = tx_data_q;
   assign o_tx_valid = tx_valid_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_checksum = checksum_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: a byte-array memory model, a
// handshake monitor and a reference model that derives the expected byte
// stream and checksum directly from base address and word count.
module tb_mem_dump_reader;

   localparam int AW = 12;
   localparam int CW = 11;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic          i_start;
   logic [AW-1:0] i_base_addr;
   logic [CW-1:0] i_word_count;
   logic [AW-1:0] o_mem_addr;
   logic [7:0]    i_mem_data;
   logic [7:0]    o_tx_data;
   logic          o_tx_valid;
   logic          i_tx_ready;
   logic          o_busy;
   logic          o_done;
   logic [7:0]    o_checksum;

   logic [7:0]    mem [0:4095];

   int            checks = 0;
   int            errors = 0;
   logic [7:0]    hs_q [$];
   int            cyc = 0;
   int            last_hs_cyc = 0;
   int            done_pulses = 0;
   int            rdy_prob = 100;
   int            stall_at = -1;
   int            stall_left = 0;

   mem_dump_reader #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_base_addr  (i_base_addr),
      .i_word_count (i_word_count),
      .o_mem_addr   (o_mem_addr),
      .i_mem_data   (i_mem_data),
      .o_tx_data    (o_tx_data),
      .o_tx_valid   (o_tx_valid),
      .i_tx_ready   (i_tx_ready),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_checksum   (o_checksum)
   );

   assign i_mem_data = mem[o_mem_addr];

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next falling edge; outputs are stable here
   task automatic tick();
      @(negedge i_clk);
      #1;
   endtask

   // Handshake monitor: records accepted bytes and checks hold-while-stalled
   initial begin
      logic       prev_valid;
      logic       prev_hs;
      logic [7:0] prev_data;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      prev_data  = 8'h00;
      forever begin
         @(negedge i_clk);
         cyc++;
         if (i_reset !== 1'b1) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
         end else begin
            if (prev_valid && !prev_hs) begin
               check("hold_valid", 32'(o_tx_valid), 32'd1);
               check("hold_data", 32'(o_tx_data), 32'(prev_data));
            end
            if (o_done === 1'b1) done_pulses++;
            prev_hs = (o_tx_valid === 1'b1) && (i_tx_ready === 1'b1);
            if (prev_hs) begin
               hs_q.push_back(o_tx_data);
               last_hs_cyc = cyc;
            end
            prev_valid = (o_tx_valid === 1'b1);
            prev_data  = o_tx_data;
         end
      end
   end

   // Transmitter model: random readiness, plus an optional 5-cycle stall on one byte
   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         if (stall_at >= 0 && o_tx_valid === 1'b1 && hs_q.size() == stall_at && stall_left > 0) begin
            i_tx_ready = 1'b0;
            stall_left--;
         end else begin
            i_tx_ready = ($urandom_range(99) < rdy_prob);
         end
      end
   end

   // One dump request checked end to end against the reference model
   task automatic run_dump(input logic [AW-1:0] base, input int count, input int prob,
                           input int stall, input bit restart);
      logic [7:0]    exp_q [$];
      logic [7:0]    exp_cs;
      logic [AW-1:0] a;
      logic [AW-1:0] end_addr;
      int            n;
      exp_cs = 8'h00;
      for (int i = 0; i < count * 4; i++) begin
         a = base + AW'(i);
         exp_q.push_back(mem[a]);
         exp_cs = exp_cs ^ mem[a];
      end
      end_addr = base + AW'(count * 4);

      hs_q.delete();
      rdy_prob    = prob;
      stall_at    = stall;
      stall_left  = 5;
      done_pulses = 0;

      i_base_addr  = base;
      i_word_count = CW'(count);
      i_start      = 1'b1;
      tick();
      i_start      = 1'b0;
      i_base_addr  = AW'($urandom);
      i_word_count = CW'($urandom);

      check("busy_after_start", 32'(o_busy), 32'd1);
      check("no_valid_first_cycle", 32'(o_tx_valid), 32'd0);
      if (count == 0) begin
         check("zero_done_now", 32'(o_done), 32'd1);
      end else begin
         tick();
         check("first_valid_latency", 32'(o_tx_valid), 32'd1);
         check("first_byte", 32'(o_tx_data), 32'(exp_q[0]));
      end

      n = 0;
      while (o_done !== 1'b1 && n < 2000) begin
         if (restart && n == 6) begin
            i_start      = 1'b1;
            i_base_addr  = base + 12'h100;
            i_word_count = CW'(7);
         end else begin
            i_start = 1'b0;
         end
         tick();
         n++;
      end
      i_start = 1'b0;
      check("done_seen", 32'(o_done), 32'd1);
      if (count > 0) begin
         check("done_after_last_hs", 32'(cyc - last_hs_cyc), 32'd1);
      end
      check("checksum_at_done", 32'(o_checksum), 32'(exp_cs));

      tick();
      check("done_one_cycle", 32'(o_done), 32'd0);
      check("idle_not_busy", 32'(o_busy), 32'd0);
      check("idle_no_valid", 32'(o_tx_valid), 32'd0);
      check("done_pulses", 32'(done_pulses), 32'd1);
      check("checksum_hold", 32'(o_checksum), 32'(exp_cs));
      check("end_addr", 32'(o_mem_addr), 32'(end_addr));
      check("byte_count", 32'(hs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
         check($sformatf("byte[%0d]", i), 32'(hs_q[i]), 32'(exp_q[i]));
      end
      rdy_prob = 100;
      stall_at = -1;
   endtask

   initial begin
      int n;
      int seen_valid;
      int seen_busy;

      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) mem[12'h010 + i] = 8'(i + 1);
      mem[12'hFFE] = 8'hAA;
      mem[12'hFFF] = 8'hBB;
      mem[12'h000] = 8'hCC;
      mem[12'h001] = 8'hDD;

      i_reset      = 1'b0;
      i_start      = 1'b0;
      i_base_addr  = '0;
      i_word_count = '0;
      i_tx_ready   = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(o_tx_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_data", 32'(o_tx_data), 32'd0);
      check("rst_checksum", 32'(o_checksum), 32'd0);
      check("rst_addr", 32'(o_mem_addr), 32'd0);
      i_reset = 1'b1;
      tick();

      // Basic two-word dump, ready always high
      run_dump(12'h010, 2, 100, -1, 1'b0);
      check("basic_checksum_08", 32'(o_checksum), 32'h08);
      // Same dump with a 5-cycle stall on byte 3
      run_dump(12'h010, 2, 100, 2, 1'b0);
      // Address wrap at the top of memory
      run_dump(12'hFFE, 1, 100, -1, 1'b0);
      // Zero-length dump
      run_dump(12'h123, 0, 100, -1, 1'b0);
      check("zero_checksum", 32'(o_checksum), 32'd0);
      // Start pulsed again mid-dump must be ignored
      run_dump(12'h010, 2, 100, -1, 1'b1);

      // Reset in the middle of a dump after the third byte
      hs_q.delete();
      rdy_prob     = 100;
      i_base_addr  = 12'h010;
      i_word_count = CW'(2);
      i_start      = 1'b1;
      tick();
      i_start = 1'b0;
      n = 0;
      while (hs_q.size() < 3 && n < 200) begin
         tick();
         n++;
      end
      check("three_bytes_before_reset", 32'(hs_q.size()), 32'd3);
      tick();
      i_reset = 1'b0;
      #1;
      check("midrst_valid", 32'(o_tx_valid), 32'd0);
      check("midrst_busy", 32'(o_busy), 32'd0);
      check("midrst_done", 32'(o_done), 32'd0);
      check("midrst_data", 32'(o_tx_data), 32'd0);
      check("midrst_checksum", 32'(o_checksum), 32'd0);
      check("midrst_addr", 32'(o_mem_addr), 32'd0);
      tick();
      tick();
      i_reset = 1'b1;
      seen_valid = 0;
      seen_busy  = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (o_tx_valid !== 1'b0) seen_valid++;
         if (o_busy !== 1'b0) seen_busy++;
      end
      check("no_resend_valid", 32'(seen_valid), 32'd0);
      check("no_resend_busy", 32'(seen_busy), 32'd0);

      // Randomized dumps, including bases near the wrap point
      for (int t = 0; t < 10; t++) begin
         logic [AW-1:0] b;
         if (t % 3 == 0) b = 12'hFF0 + AW'($urandom_range(15));
         else            b = AW'($urandom);
         run_dump(b, int'($urandom_range(5)), int'($urandom_range(100, 30)), -1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
